// File: rtl/clk_divider_prog.sv
// Runtime-programmable integer clock divider: registered divided clock plus a
// period-start strobe, with a shadowed divisor that commits at period boundaries.
module clk_divider_prog #(
    parameter int WIDTH       = 16,
    parameter int DEFAULT_DIV = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic             i_sync,
    input  logic [WIDTH-1:0] i_div,
    input  logic             i_div_load,
    output logic             o_clk,
    output logic             o_tick,
    output logic             o_busy,
    output logic [WIDTH-1:0] o_div
);

    localparam logic [WIDTH-1:0] MIN_DIV   = WIDTH'(2);
    localparam logic [WIDTH-1:0] RESET_DIV = (DEFAULT_DIV < 2) ? MIN_DIV : WIDTH'(DEFAULT_DIV);

    function automatic logic [WIDTH-1:0] clamp_div(input logic [WIDTH-1:0] value);
        return (value < MIN_DIV) ? MIN_DIV : value;
    endfunction

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] shadow;
    logic [WIDTH-1:0] half;
    logic [WIDTH-1:0] cnt_inc;
    logic [WIDTH-1:0] sync_div;
    logic             wrap;

    // High phase is ceil(N/2); cnt_inc cannot overflow because it is only
    // used when cnt < N-1.
    always_comb begin
        half     = o_div - (o_div >> 1);
        cnt_inc  = cnt + WIDTH'(1);
        wrap     = (cnt == o_div - WIDTH'(1));
        sync_div = o_busy ? shadow : o_div;
    end

    // NOTE: non-blocking assignments make every register sample pre-edge
    // values, so a wrap commits the previously pending shadow even when a new
    // load lands on the same edge, and a later load assignment to o_busy wins.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt    <= RESET_DIV - WIDTH'(1);
            o_div  <= RESET_DIV;
            shadow <= '0;
            o_busy <= 1'b0;
            o_clk  <= 1'b0;
            o_tick <= 1'b0;
        end else begin
            if (i_sync) begin
                // Park the counter on the last count so the next enabled edge
                // begins a full period.
                o_div  <= sync_div;
                cnt    <= sync_div - WIDTH'(1);
                o_busy <= 1'b0;
                o_clk  <= 1'b0;
                o_tick <= 1'b0;
            end else if (i_en) begin
                if (wrap) begin
                    cnt    <= '0;
                    o_tick <= 1'b1;
                    o_clk  <= 1'b1;
                    if (o_busy) begin
                        o_div  <= shadow;
                        o_busy <= 1'b0;
                    end
                end else begin
                    cnt    <= cnt_inc;
                    o_tick <= 1'b0;
                    o_clk  <= (cnt_inc < half);
                end
            end else begin
                o_tick <= 1'b0;
            end

            // Captured after any commit above, so it always becomes the new pending value.
            if (i_div_load) begin
                shadow <= clamp_div(i_div);
                o_busy <= 1'b1;
            end
        end
    end

endmodule

// File: doc/clk_divider_prog.md
Name: clk_divider_prog

Overview:
Runtime-programmable integer clock divider, the successor to the fixed clk_divider. It produces a registered divided clock o_clk and a one-cycle period-start strobe o_tick, both synchronous to i_clk. The divisor width is a parameter, and the divisor is reloadable at runtime without glitches; a new value takes effect at a period boundary. Supports count enable, synchronous phase restart, and odd divisors. Used as a clock-enable / slow-clock source for the motion-control datapath and serial peripherals.

Parameters:
WIDTH, 16, divisor and counter width in bits
DEFAULT_DIV, 4, divisor loaded at reset; clamped like runtime loads

Ports:
i_clk  input  1  system clock; all logic on rising edge
i_rst  input  1  synchronous reset, active-high
i_en  input  1  count enable; 0 freezes counter and outputs
i_sync  input  1  synchronous phase restart; single-cycle pulse
i_div  input  WIDTH  new divisor value N
i_div_load  input  1  capture i_div into shadow register; single-cycle pulse
o_clk  output  1  divided clock, registered
o_tick  output  1  one-cycle strobe in the first cycle of each period
o_busy  output  1  shadow divisor pending, not yet committed
o_div  output  WIDTH  active (clamped) divisor

Behaviour:
- Reset and synchronous restart are synchronous and active-high. Clock and reset ports are i_clk and i_rst.
- Clamp: any divisor < 2 (load or DEFAULT_DIV) becomes 2. Active N is always in [2, 2^WIDTH-1]. H = N - (N>>1), i.e. ceil(N/2).
- Reset values:
  - cnt = clamp(DEFAULT_DIV)-1; N = clamp(DEFAULT_DIV).
  - o_clk=0, o_tick=0, o_busy=0, o_div=N.
  - Shadow register = 0.
- Priority: i_rst > i_sync > enabled count > hold.
- Enabled cycle (i_en=1):
  - If cnt==N-1 (wrap): cnt<=0, o_tick<=1, o_clk<=1. If o_busy, also N<=shadow and o_busy<=0 (commit).
  - Otherwise: cnt<=cnt+1, o_tick<=0, o_clk<=(cnt+1 < H).
- Resulting waveform:
  - o_clk is high for H cycles, low for N-H cycles.
  - o_tick is coincident with each o_clk rising cycle.
  - First enabled edge after reset or sync starts a full period, with no partial first period.
- i_en=0: cnt, N, and o_clk hold; o_tick<=0. Loads are still captured; commit waits for the next wrap.
- i_div_load:
  - shadow<=clamp(i_div), o_busy<=1.
  - A load while busy overwrites the shadow (last value wins).
  - Load on the same edge as a wrap: the commit uses the previously pending shadow if busy, otherwise nothing is committed. The new value becomes pending and o_busy stays/goes 1.
- i_sync:
  - If busy, commit the pending shadow immediately (o_busy<=0).
  - cnt<=N_new-1, o_clk<=0, o_tick<=0.
  - Takes effect regardless of i_en.
  - A load on the same edge as sync is captured as pending after the commit.
- o_div changes only at commit, reset, or sync, on the same edge as the new cnt.
- Max N: cnt never exceeds N-1, and N-1 never overflows WIDTH.
- Reset mid-period or mid-pending: the pending load is discarded and all state returns to reset values on the next edge.

Test Plan:
1. DEFAULT_DIV=4, deassert i_rst, i_en=1 -> o_tick at enabled edges 1,5,9,...; o_clk pattern 1100 repeating; o_div=4, o_busy=0.
2. Load 5 and let it commit -> o_clk 3 high / 2 low; o_tick every 5 cycles; o_div=5 from the commit edge.
3. N=4, pulse load i_div=10 at cnt=1 -> o_busy=1 until the wrap 3 cycles later. That period still lasts 4 cycles; subsequent periods are 10 (5 high / 5 low); o_busy=0 and o_div=10 at the wrap.
4. Load i_div=0, then i_div=1 -> o_div=2 after commit; o_clk toggles every cycle; o_tick every 2nd cycle.
5. i_en=0 for 7 cycles during the high phase -> o_clk frozen at 1, o_tick=0, cnt held. After re-enable the period resumes with the remaining count, with no extra tick.
6. Pending load 6 plus i_sync mid-period -> immediate commit, o_div=6, o_clk=0, tick on the next enabled edge. Then load 8 and assert i_rst with it pending -> o_busy=0, o_div=4, and the 1100 pattern resumes.
